// File: rtl/sha256_round_sequencer.sv
// SHA-256 message-schedule sequencer: loads a 16-word block, then streams W0..W(ROUNDS-1)
// to the compression core one round per handshake, with block/message completion pulses.
module sha256_round_sequencer #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [31:0] msg_data,
    input  logic        msg_first,
    input  logic        msg_last,
    input  logic        abort,
    output logic        rnd_valid,
    input  logic        rnd_ready,
    output logic [5:0]  rnd_idx,
    output logic [31:0] rnd_w,
    output logic        rnd_init,
    output logic        rnd_last,
    output logic        busy,
    output logic        blk_done,
    output logic        msg_done
);

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned WIN_LEN  = 16;
    localparam logic [5:0]  LAST_IDX = 6'(ROUNDS - 1);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic [WORD_W-1:0]  win_q [WIN_LEN];
    logic [3:0]         cnt_q;
    logic [5:0]         idx_q;
    logic               first_q;
    logic               last_q;
    logic               blk_done_q;
    logic               msg_done_q;
    logic [WORD_W-1:0]  sched_d;

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Next schedule word W[t+16] from the current window W[t..t+15].
    always_comb begin
        sched_d = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            idx_q      <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            blk_done_q <= 1'b0;
            msg_done_q <= 1'b0;
            for (int k = 0; k < WIN_LEN; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            blk_done_q <= 1'b0;
            msg_done_q <= 1'b0;
            if (abort) begin
                // Cancel wins over any handshake; window contents are left as-is.
                state_q <= S_LOAD;
                cnt_q   <= '0;
                idx_q   <= '0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (msg_valid) begin
                            for (int k = 0; k < WIN_LEN - 1; k++) begin
                                win_q[k] <= win_q[k+1];
                            end
                            win_q[WIN_LEN-1] <= msg_data;
                            if (cnt_q == 4'd0) begin
                                first_q <= msg_first;
                                last_q  <= msg_last;
                            end
                            cnt_q <= cnt_q + 4'd1;
                            if (cnt_q == 4'd15) begin
                                idx_q   <= '0;
                                state_q <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (rnd_ready) begin
                            for (int k = 0; k < WIN_LEN - 1; k++) begin
                                win_q[k] <= win_q[k+1];
                            end
                            win_q[WIN_LEN-1] <= sched_d;
                            if (idx_q == LAST_IDX) begin
                                state_q    <= S_LOAD;
                                idx_q      <= '0;
                                blk_done_q <= 1'b1;
                                msg_done_q <= last_q;
                            end else begin
                                idx_q <= idx_q + 6'd1;
                            end
                        end
                    end
                    default: state_q <= S_LOAD;
                endcase
            end
        end
    end

    // Outputs are pure decodes of registered state.
    assign msg_ready = (state_q == S_LOAD);
    assign rnd_valid = (state_q == S_RUN);
    assign rnd_idx   = idx_q;
    assign rnd_w     = win_q[0];
    assign rnd_init  = (state_q == S_RUN) && first_q && (idx_q == 6'd0);
    assign rnd_last  = (state_q == S_RUN) && (idx_q == LAST_IDX);
    assign busy      = (state_q == S_RUN) || (cnt_q != 4'd0);
    assign blk_done  = blk_done_q;
    assign msg_done  = msg_done_q;

endmodule

// File: doc/sha256_round_sequencer.md
# sha256_round_sequencer

Control and message-schedule block between the coprocessor's AXI4-Lite register front end and the SHA-256 compression core. It collects one 512-bit block as sixteen 32-bit words and expands them into the 64-entry message schedule W0..W63. It then issues one round per handshake to the core, with round index, W_t and first/last markers. It also reports per-block and per-message completion back to the control registers.

## Interface
- ROUNDS, 64: rounds issued per block; legal range 16..64.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- msg_valid  in  1  word on msg_data is valid.
- msg_ready  out  1  block accepts a word.
- msg_data  in  32  message word; word 0 is the most significant word of the block.
- msg_first  in  1  block starts a new message; sampled with word 0 only.
- msg_last  in  1  block ends the message; sampled with word 0 only.
- abort  in  1  synchronous cancel of the current block.
- rnd_valid  out  1  round command valid.
- rnd_ready  in  1  compression core accepts the round.
- rnd_idx  out  6  round number t.
- rnd_w  out  32  schedule word W_t.
- rnd_init  out  1  core must load the initial hash H0 before round t; asserted only at t=0 of a first block.
- rnd_last  out  1  t = ROUNDS-1.
- busy  out  1  a block is partially loaded or running.
- blk_done  out  1  one-cycle pulse when a block completes.
- msg_done  out  1  one-cycle pulse when a last block completes.

## Operation
- States:
  - LOAD: msg_ready=1, rnd_valid=0.
  - RUN: msg_ready=0, rnd_valid=1.
- Storage:
  - 16x32 window `win[0..15]`, where win[k] = W[t+k].
  - 4-bit word count.
  - 6-bit round counter.
  - Stored first/last flags.
- LOAD phase:
  - Each msg handshake shifts the window down by one (win[k] <= win[k+1]) and writes win[15] <= msg_data, then increments the word count.
  - On the word-0 handshake, msg_first and msg_last are captured.
  - The 16th handshake sets word count to 0, round counter to 0, and state to RUN.
- RUN phase outputs:
  - rnd_w = win[0]
  - rnd_idx = round counter
  - rnd_init = first_flag && idx==0
  - rnd_last = idx==ROUNDS-1
- RUN phase on each rnd handshake:
  - Shift the window down and write win[15] <= s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^32.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Increment the round counter.
- Block completion: the handshake at idx==ROUNDS-1 moves state to LOAD and registers blk_done=1 for the next cycle, plus msg_done=1 if last_flag is set.
- Flow control:
  - rnd_valid, once high, stays high with rnd_idx, rnd_w, rnd_init and rnd_last stable until the handshake.
  - No combinational path from rnd_ready to rnd_valid.
- Status: busy = (state==RUN) || (word count != 0).
- abort priority:
  - Wins over any handshake in the same cycle; that handshake is discarded.
  - Next state is LOAD with word count and round counter cleared and flags cleared.
  - No blk_done or msg_done pulse.
  - Window contents are don't-care.
- ARESET priority: highest; same clearing effect as abort, and additionally clears the window to 0.

## Timing
- After a clock edge with ARESET=1:
  - msg_ready=1.
  - rnd_valid, rnd_idx, rnd_w, rnd_init, rnd_last, busy, blk_done and msg_done all 0.
- All outputs derive from registers only; no input-to-output combinational paths.
- Load-to-first-round latency: the 16th word handshake at edge N gives rnd_valid=1 with idx 0 in cycle N+1.
- Block throughput with rnd_ready held high: 16 load cycles + ROUNDS run cycles.
- Completion timing: the last-round handshake at edge M gives blk_done and msg_done pulses in cycle M+1, with msg_ready=1 in that same cycle, so the next block may load immediately.
- Boundary behaviour:
  - msg_valid during RUN is ignored and the word is not consumed.
  - A partial block (count 1..15) waits indefinitely.
  - The round counter never wraps, because the exit is taken at ROUNDS-1.

## Test plan
- Reset: assert ARESET for 3 cycles mid-RUN -> next cycle msg_ready=1, rnd_valid=0, busy=0, all pulses 0.
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018, first=last=1), rnd_ready=1:
  - Required rnd_w at idx0 = 0x61626380, idx15 = 0x00000018, idx16 = 0x61626380, idx17 = 0x000F0000.
  - rnd_init only at idx0; rnd_last only at idx63.
  - blk_done and msg_done both pulse exactly once, one cycle after the idx63 handshake.
- Backpressure: random rnd_ready at 30% duty -> rnd_idx/rnd_w stable while stalled; exactly 64 handshakes; W values identical to the unstalled run.
- Two-block message (first=1/last=0, then first=0/last=1):
  - rnd_init only in block 1.
  - blk_done pulses twice; msg_done only after block 2.
  - msg_valid held high during RUN consumes no words.
- Abort at idx30, with rnd_ready asserted in the same cycle -> next cycle LOAD, no done pulses; a following block restarts at idx0 with correct W0.
- Partial load: 7 words then ARESET -> busy=0; the next 16 words form a complete block whose idx0 equals the first word sent after reset.
